// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter.
// FSM state and owner encodings, starvation counter width, saturating increment helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arbState_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam int STARVE_W = 4;

   function automatic logic [STARVE_W-1:0] satInc(
      input logic [STARVE_W-1:0] v
   );
      return (&v) ? v : v + STARVE_W'(1);
   endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Fetch-starvation counter: counts data grants made while fetch waits.
// Ports: clk, rst, incEn (D grant with fetch pending), clrEn, forceFetch (count == STARVE_MAX).
module arb_starve_counter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic incEn,
   input  logic clrEn,
   output logic forceFetch
);

   logic [STARVE_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clrEn) begin
         count <= '0;
      end else if (incEn) begin
         count <= satInc(count);
      end
   end

   assign forceFetch = (count == STARVE_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one request/grant/response memory port between fetch (i_*) and load/store (d_*).
// Ports: fetch req/ack/rdata, data req/we/addr/wdata/ack/rdata, mem req/gnt/rvalid bus, stall_if/stall_mem.
// Optional fetch anti-starvation: define MEM_PORT_ARB_STARVE_EN (default build is strict D priority).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_ack,
   input  logic                d_req,
   input  logic [DATA_W/8-1:0] d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ack,
   output logic                mem_req,
   output logic [DATA_W/8-1:0] mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall_if,
   output logic                stall_mem
);

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : gBadStarve
      $error("STARVE_MAX must be within 1..15");
   end
   if (DATA_W % 8 != 0) begin : gBadData
      $error("DATA_W must be a multiple of 8");
   end

   arbState_t state;
   arbState_t stateNext;
   owner_t    owner;
   logic      anyReq;
   logic      arbNow;
   logic      pickD;

   assign anyReq = i_req | d_req;
   assign arbNow = (state == IDLE) && anyReq;

`ifdef MEM_PORT_ARB_STARVE_EN
   logic forceFetch;

   // Fetch overrides D only when it has waited out STARVE_MAX data grants.
   assign pickD = d_req && !(forceFetch && i_req);

   arb_starve_counter #(
      .STARVE_MAX(STARVE_MAX)
   ) uStarve (
      .clk       (clk),
      .rst       (rst),
      .incEn     (arbNow && pickD && i_req),
      .clrEn     ((state == IDLE) && (!i_req || !pickD)),
      .forceFetch(forceFetch)
   );
`else
   assign pickD = d_req;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (anyReq) stateNext = ISSUE;
         ISSUE:   if (mem_gnt) stateNext = WAIT;
         WAIT:    if (mem_rvalid) stateNext = RESP;
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Request fields are latched once at arbitration and held through ISSUE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner     <= OWN_I;
         mem_addr  <= '0;
         mem_we    <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         if (arbNow) begin
            if (pickD) begin
               owner     <= OWN_D;
               mem_addr  <= d_addr;
               mem_we    <= d_we;
               mem_wdata <= d_wdata;
            end else begin
               owner     <= OWN_I;
               mem_addr  <= i_addr;
               mem_we    <= '0;
               mem_wdata <= '0;
            end
         end
         // Ack rises as the FSM enters RESP, so it lasts exactly one cycle.
         if ((state == WAIT) && mem_rvalid) begin
            if (owner == OWN_D) begin
               d_rdata <= mem_rdata;
               d_ack   <= 1'b1;
            end else begin
               i_rdata <= mem_rdata;
               i_ack   <= 1'b1;
            end
         end
      end
   end

   assign mem_req   = (state == ISSUE);
   assign stall_if  = i_req && !i_ack;
   assign stall_mem = d_req && !d_ack;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the core's single unified memory port between the instruction-fetch requester (F stage) and the load/store requester (M stage) of the 3-stage RISC-V pipeline. It serialises both requesters onto one request/grant/response memory interface with one transaction outstanding at a time. It returns read data and a one-cycle acknowledge to the winning requester, and drives per-requester stall outputs that the pipeline ORs into its existing stall/flush control.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- STARVE_MAX, 4, consecutive data grants with fetch waiting before fetch is forced to win; range 1..15

Ports:
- clk  in  1  single clock, all logic on the rising edge
- rst  in  1  reset; asynchronous, active-high
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  ADDR_W  fetch address; stable while i_req
- i_rdata  out  DATA_W  fetch data; valid while i_ack
- i_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  load/store request; held until d_ack
- d_we  in  DATA_W/8  byte write enables; all zero means load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid while d_ack
- d_ack  out  1  one-cycle load/store completion pulse
- mem_req  out  1  memory request; held until mem_gnt
- mem_we  out  DATA_W/8  byte enables for the granted request
- mem_addr  out  ADDR_W  address for the granted request
- mem_wdata  out  DATA_W  store data for the granted request
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response for the accepted request; also returned for stores
- mem_rdata  in  DATA_W  response data
- stall_if  out  1  i_req && !i_ack
- stall_mem  out  1  d_req && !d_ack

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Register `owner` records the winner, I or D.
- IDLE:
  - If any request is pending, pick the winner and register mem_addr, mem_we and mem_wdata from it. mem_we is forced to 0 for fetches. Then go to ISSUE.
  - Default priority: D over I.
- ISSUE:
  - mem_req=1 and the registered request fields are held stable.
  - On mem_gnt, go to WAIT.
- WAIT:
  - On mem_rvalid, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP:
  - Assert the owner's ack for exactly one cycle, then return to IDLE.
  - A request still pending, or a new one, is arbitrated in the following IDLE cycle.
- mem_rvalid in IDLE, ISSUE or RESP is ignored.
- mem_gnt outside ISSUE is ignored.
- i_rdata and d_rdata hold their last captured value between acks.
- stall_if and stall_mem are combinational from the inputs and the ack registers.
- Requesters must not change req or the request fields between assertion and ack. The arbiter does not check this; fields are sampled only in IDLE.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, state=IDLE, owner=I, starvation count=0.
- Best-case latency:
  - Request seen in IDLE at cycle 0.
  - mem_req high at cycle 1; gnt also at cycle 1.
  - rvalid at cycle 2.
  - ack at cycle 3.
  - Every added gnt or rvalid wait cycle adds one cycle.
- Back-to-back transactions: one transaction per 4 cycles minimum, because RESP→IDLE always takes one cycle.
- Simultaneous i_req and d_req in IDLE: D wins unless the forced-fetch rule below applies.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with mem_req=0.
  - No ack is produced for the aborted transaction.
  - A late mem_rvalid after reset is ignored.

## Configuration
- MEM_PORT_ARB_STARVE_EN defined:
  - A 4-bit counter increments on each D grant made while i_req is pending.
  - It clears on each I grant, and also whenever i_req is low in IDLE.
  - When the counter equals STARVE_MAX and both requests are pending, I wins.
- Not defined: strict D priority. The counter logic is not compiled in, and fetch may starve under continuous load/store traffic.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding localparams IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
  - owner encoding OWN_I=1'b0, OWN_D=1'b1
  - STARVE_W=4
- One sub-module: `arb_starve_counter`, the saturating counter plus compare, compiled only under the macro.

## Test plan
- Single fetch: i_req, i_addr=0x100; gnt and rvalid each immediate with rdata=0xDEADBEEF → mem_req at cycle 1, i_ack at cycle 3 with i_rdata=0xDEADBEEF; stall_if high for cycles 0–2.
- Simultaneous i_req (addr 0x200) and store d_req (addr 0x40, we=4'b1111, wdata=0x12345678) → store issued first with mem_we=4'hF; d_ack, then fetch issued with mem_we=0, then i_ack.
- Memory wait states: gnt delayed 2 cycles, rvalid delayed 3 cycles → ack at cycle 8; mem_req and request fields stable throughout ISSUE.
- Starvation, macro on, STARVE_MAX=4: d_req held continuously with i_req pending → exactly 4 d_acks, then one i_ack, then D resumes. Macro off: no i_ack while d_req stays high.
- Reset in WAIT: assert rst, then mem_rvalid the next cycle → all outputs at reset values, no ack, state IDLE.
- Byte store: d_we=4'b0010 → mem_we=4'b0010 while mem_req is high; d_ack after rvalid.
